// File: rtl/rect_copy_sequencer.sv
// Copies RECT_COUNT rects (x,y,w,h,color) from data memory to the GPU as absolute edges.
// Latency: mem_addr 1 cycle after frame_start, gpu_copy_start at +2, word n at +3+n, done at +3+5*RECT_COUNT.
// Backpressure: none; the GPU receiver must accept one word per cycle, frame_start while busy is dropped.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   frame_start       one-cycle pulse at start of vertical blank
//   mem_addr/mem_din  data-memory read port, read data valid one cycle after the address
//   gpu_copy_start    one-cycle trigger to the GPU receiver
//   gpu_dout          registered word stream: left, top, right, bottom, color per rect
//   busy, done        copy in progress / one-cycle completion pulse (busy already low)
//
// Build option: define RECT_CLIP_EN to saturate right/bottom at 16'hFFFF instead of
// wrapping modulo 2^16. Timing is identical in both builds.
module rect_copy_sequencer #(
  parameter int RECT_COUNT       = 64,
  parameter int RECT_COUNT_WIDTH = 6,
  parameter int ADDR_WIDTH       = 16,
  parameter int BASE_ADDR        = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           mem_din,
  output logic                  gpu_copy_start,
  output logic [15:0]           gpu_dout,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0]       BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [RECT_COUNT_WIDTH-1:0] LAST_RECT = RECT_COUNT_WIDTH'(RECT_COUNT - 1);

  state_t                      state;
  state_t                      state_next;
  logic [2:0]                  word_cnt;
  logic [RECT_COUNT_WIDTH-1:0] rect_cnt;
  logic                        rd_vld;
  logic                        rd_last;
  logic [2:0]                  rd_word;
  logic                        out_last;
  logic [15:0]                 x_lat;
  logic [15:0]                 y_lat;
  logic                        fetch_en;
  logic                        fetch_last;
  logic                        finish;

  function automatic logic [15:0] edge_sum(input logic [15:0] a, input logic [15:0] b);
`ifdef RECT_CLIP_EN
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    edge_sum = s[16] ? 16'hFFFF : s[15:0];
`else
    edge_sum = a + b;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    fetch_en   = 1'b0;
    fetch_last = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE:  if (frame_start) state_next = FETCH;
      FETCH: begin
        fetch_en = 1'b1;
        if (word_cnt == 3'd4 && rect_cnt == LAST_RECT) begin
          fetch_last = 1'b1;
          state_next = DRAIN;
        end
      end
      // DRAIN covers the memory read latency plus the output register stage.
      DRAIN: if (out_last) begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr       <= BASE;
      word_cnt       <= 3'd0;
      rect_cnt       <= '0;
      rd_vld         <= 1'b0;
      rd_last        <= 1'b0;
      rd_word        <= 3'd0;
      out_last       <= 1'b0;
      x_lat          <= 16'd0;
      y_lat          <= 16'd0;
      gpu_copy_start <= 1'b0;
      gpu_dout       <= 16'd0;
      done           <= 1'b0;
    end else begin
      if (fetch_en) begin
        if (fetch_last) begin
          // Park everything at rect 0 so the next frame starts clean.
          mem_addr <= BASE;
          word_cnt <= 3'd0;
          rect_cnt <= '0;
        end else begin
          mem_addr <= mem_addr + ADDR_WIDTH'(1);
          if (word_cnt == 3'd4) begin
            word_cnt <= 3'd0;
            rect_cnt <= rect_cnt + RECT_COUNT_WIDTH'(1);
          end else begin
            word_cnt <= word_cnt + 3'd1;
          end
        end
      end

      // Tags travel alongside the address so they line up with mem_din.
      rd_vld         <= fetch_en;
      rd_word        <= word_cnt;
      rd_last        <= fetch_last;
      out_last       <= rd_vld && rd_last;
      gpu_copy_start <= fetch_en && (word_cnt == 3'd0) && (rect_cnt == '0);
      done           <= finish;

      if (rd_vld) begin
        case (rd_word)
          3'd0: begin x_lat <= mem_din; gpu_dout <= mem_din; end
          3'd1: begin y_lat <= mem_din; gpu_dout <= mem_din; end
          3'd2:       gpu_dout <= edge_sum(x_lat, mem_din);
          3'd3:       gpu_dout <= edge_sum(y_lat, mem_din);
          default:    gpu_dout <= mem_din;
        endcase
      end else begin
        gpu_dout <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_rect_copy_sequencer.sv
// Testbench for rect_copy_sequencer: a 2-rect instance driven through a scoreboard monitor,
// plus a 64-rect instance at base 16'h0100 checked over a full frame.
// Honours RECT_CLIP_EN in its own reference sum.
module tb_rect_copy_sequencer;

  localparam int N_S    = 2;
  localparam int W_S    = 5 * N_S;
  localparam int BASE_S = 8;
  localparam int N_L    = 64;
  localparam int BASE_L = 16'h0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fs_s = 1'b0;
  logic        fs_l = 1'b0;
  logic [15:0] addr_s, din_s, dout_s, addr_l, din_l, dout_l;
  logic        cs_s, busy_s, done_s, cs_l, busy_l, done_l;

  logic [15:0] mem_s [0:63];
  logic [15:0] mem_l [0:1023];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] exp_q [$];
  int          start_q [$];
  int          done_q [$];
  logic [15:0] q64 [$];
  int win_lo = -100;
  int win_hi = -100;
  int words_left = 0;
  int abort_at = -1;

  rect_copy_sequencer #(
    .RECT_COUNT(N_S), .RECT_COUNT_WIDTH(1), .ADDR_WIDTH(16), .BASE_ADDR(BASE_S)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(fs_s), .mem_addr(addr_s), .mem_din(din_s),
    .gpu_copy_start(cs_s), .gpu_dout(dout_s), .busy(busy_s), .done(done_s)
  );

  rect_copy_sequencer #(
    .BASE_ADDR(BASE_L)
  ) dut64 (
    .clk(clk), .reset(reset), .frame_start(fs_l), .mem_addr(addr_l), .mem_din(din_l),
    .gpu_copy_start(cs_l), .gpu_dout(dout_l), .busy(busy_l), .done(done_l)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    din_s <= mem_s[addr_s[5:0]];
    din_l <= mem_l[addr_l[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sum16(input logic [15:0] a, input logic [15:0] b);
`ifdef RECT_CLIP_EN
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > 17'h0FFFF) ? 16'hFFFF : s[15:0];
`else
    return a + b;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rect(input int r, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] w, input logic [15:0] h, input logic [15:0] c);
    mem_s[BASE_S + 5*r + 0] = x;
    mem_s[BASE_S + 5*r + 1] = y;
    mem_s[BASE_S + 5*r + 2] = w;
    mem_s[BASE_S + 5*r + 3] = h;
    mem_s[BASE_S + 5*r + 4] = c;
  endtask

  // Pulse frame_start on the small instance; if the model says it is idle, queue the expected frame.
  task automatic start_small();
    int t;
    int b;
    t = cyc;
    fs_s = 1'b1;
    if (t > win_hi) begin
      for (int r = 0; r < N_S; r++) begin
        b = BASE_S + 5*r;
        exp_q.push_back(mem_s[b]);
        exp_q.push_back(mem_s[b+1]);
        exp_q.push_back(sum16(mem_s[b], mem_s[b+2]));
        exp_q.push_back(sum16(mem_s[b+1], mem_s[b+3]));
        exp_q.push_back(mem_s[b+4]);
      end
      start_q.push_back(t + 2);
      done_q.push_back(t + 3 + W_S);
      win_lo = t + 1;
      win_hi = t + 2 + W_S;
    end
    tick();
    fs_s = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Scoreboard monitor for the small instance.
  always @(negedge clk) begin
    if (cyc >= 2 && !reset) begin
      if (cyc == abort_at) begin
        exp_q.delete();
        start_q.delete();
        done_q.delete();
        words_left = 0;
      end
      if (cyc >= win_lo && cyc <= win_hi) begin
        check("busy", busy_s, 1);
        if (cyc <= win_lo + W_S - 1) check("addr", addr_s, BASE_S + (cyc - win_lo));
      end else begin
        check("busy", busy_s, 0);
        check("idle_dout", dout_s, 0);
        check("idle_addr", addr_s, BASE_S);
      end
      if (cs_s) begin
        if (start_q.size() == 0) check("start_unexpected", 1, 0);
        else check("start_cycle", cyc, start_q.pop_front());
        words_left = W_S;
      end else if (words_left > 0) begin
        if (exp_q.size() == 0) check("dout_unexpected", 1, 0);
        else check("dout", dout_s, exp_q.pop_front());
        words_left--;
      end
      if (done_s) begin
        check("done_busy", busy_s, 0);
        if (done_q.size() == 0) check("done_unexpected", 1, 0);
        else check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  initial begin
    int t0;
    int b;
    for (int a = 0; a < 64; a++) mem_s[a] = 16'd0;
    for (int a = 0; a < 1024; a++) mem_l[a] = 16'd0;
    for (int r = 0; r < N_L; r++) begin
      b = BASE_L + 5*r;
      mem_l[b]   = 16'(r * 1000);
      mem_l[b+1] = 16'(16'hFF00 + r);
      mem_l[b+2] = 16'(r * 40 + 1);
      mem_l[b+3] = 16'(r * 8);
      mem_l[b+4] = 16'(r) ^ 16'hA5A5;
    end

    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy_s, 0);
    check("rst_done", done_s, 0);
    check("rst_start", cs_s, 0);
    check("rst_dout", dout_s, 0);
    check("rst_addr", addr_s, BASE_S);
    check("rst_addr64", addr_l, BASE_L);
    check("rst_busy64", busy_l, 0);
    tick();

    // Reference frame.
    load_rect(0, 16'd10, 16'd20, 16'd5, 16'd7, 16'hF800);
    load_rect(1, 16'd0, 16'd0, 16'd1, 16'd1, 16'h001F);
    t0 = cyc;
    start_small();
    wait_until(t0 + 16);

    // Edge sums past 16 bits.
    load_rect(0, 16'hFFF0, 16'hFFFF, 16'h0020, 16'h0001, 16'h1234);
    load_rect(1, 16'h8000, 16'h7FFF, 16'h8000, 16'h0001, 16'h0000);
    t0 = cyc;
    start_small();
    wait_until(t0 + 16);

    // Re-pulses while busy must be ignored.
    load_rect(0, 16'd10, 16'd20, 16'd5, 16'd7, 16'hF800);
    load_rect(1, 16'd0, 16'd0, 16'd1, 16'd1, 16'h001F);
    t0 = cyc;
    start_small();
    wait_until(t0 + 4);
    start_small();
    wait_until(t0 + 8);
    start_small();
    wait_until(t0 + 16);

    // Back-to-back: second start coincides with done.
    t0 = cyc;
    start_small();
    wait_until(t0 + 13);
    start_small();
    wait_until(t0 + 30);

    // Reset mid-copy, then a fresh frame.
    load_rect(0, 16'd100, 16'd200, 16'd3, 16'd4, 16'h0F0F);
    t0 = cyc;
    start_small();
    wait_until(t0 + 6);
    reset = 1'b1;
    win_hi = cyc;
    abort_at = cyc + 1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy_s, 0);
    check("abort_dout", dout_s, 0);
    wait_until(t0 + 10);
    start_small();
    wait_until(t0 + 26);

    // Full-size instance.
    t0 = cyc;
    fs_l = 1'b1;
    for (int r = 0; r < N_L; r++) begin
      b = BASE_L + 5*r;
      q64.push_back(mem_l[b]);
      q64.push_back(mem_l[b+1]);
      q64.push_back(sum16(mem_l[b], mem_l[b+2]));
      q64.push_back(sum16(mem_l[b+1], mem_l[b+3]));
      q64.push_back(mem_l[b+4]);
    end
    tick();
    fs_l = 1'b0;
    for (int i = 0; i <= 322; i++) begin
      @(negedge clk);
      if (i < 320) check("l_addr", addr_l, BASE_L + i);
      check("l_start", cs_l, (i == 1) ? 1 : 0);
      if (i >= 2 && i < 322) check("l_dout", dout_l, q64.pop_front());
      check("l_busy", busy_l, (i <= 321) ? 1 : 0);
      check("l_done", done_l, (i == 322) ? 1 : 0);
    end

    repeat (3) tick();
    check("sb_words_left", exp_q.size(), 0);
    check("sb_starts_left", start_q.size(), 0);
    check("sb_dones_left", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
